modinv_64: RTL and testbench

- Computes the modular inverse d = e^-1 mod m, the RSA key-generation stage directly downstream of lcm_32.
- m is the Carmichael value lambda = lcm(p-1, q-1), taken from lcm_32's 64-bit result; e is the public exponent. The output d is the private exponent.
- Uses binary extended Euclid (shift/subtract/add only), so no divider or multiplier is instantiated.
- Reports err when gcd(e, m) != 1.

---
 rtl/modinv_64_pkg.sv | 18 +
 rtl/modinv_coef_half.sv | 30 +++
 rtl/modinv_64.sv | 164 ++++++++++++++++
 tb/tb_modinv_64.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/modinv_64_pkg.sv
// Shared definitions for the modular-inverse stage of RSA key generation.
package modinv_64_pkg;

    localparam int unsigned RSA_W = 64;
    localparam int unsigned G     = 3;

    typedef enum logic [2:0] {
        S_CHK,
        S_U,
        S_V,
        S_SUB,
        S_GCD,
        S_FIX,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/modinv_coef_half.sv
// Parity-conditional halving of a Bezout coefficient pair (a, b) against operands x, y.
module modinv_coef_half
    import modinv_64_pkg::*;
#(
    parameter int unsigned W = RSA_W
) (
    input  logic signed [W+G-1:0] a_in,
    input  logic signed [W+G-1:0] b_in,
    input  logic        [W-1:0]   x,
    input  logic        [W-1:0]   y,
    output logic signed [W+G-1:0] a_out,
    output logic signed [W+G-1:0] b_out
);

    logic signed [W+G:0] a_sum;
    logic signed [W+G:0] b_dif;

    // One spare bit so the add/subtract cannot wrap before the arithmetic shift.
    always_comb begin
        a_sum = {a_in[W+G-1], a_in};
        b_dif = {b_in[W+G-1], b_in};
        if (a_in[0] || b_in[0]) begin
            a_sum = {a_in[W+G-1], a_in} + $signed({{(G+1){1'b0}}, y});
            b_dif = {b_in[W+G-1], b_in} - $signed({{(G+1){1'b0}}, x});
        end
        a_out = (W+G)'(a_sum >>> 1);
        b_out = (W+G)'(b_dif >>> 1);
    end

endmodule

// File: rtl/modinv_64.sv
// d = e^-1 mod m by binary extended Euclid; rst_n low loads operands, release starts the run.
module modinv_64
    import modinv_64_pkg::*;
#(
    parameter int unsigned W = RSA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] ine,
    input  logic [W-1:0] inm,
    output logic [W-1:0] result,
    output logic         err,
    output logic         ready_n
);

    localparam int unsigned CW = W + G;

    state_t state;

    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] u;
    logic [W-1:0] v;
    logic [W-1:0] u_h;
    logic [W-1:0] v_h;

    logic signed [CW-1:0] a;
    logic signed [CW-1:0] b;
    logic signed [CW-1:0] c;
    logic signed [CW-1:0] d;
    logic signed [CW-1:0] a_h;
    logic signed [CW-1:0] b_h;
    logic signed [CW-1:0] c_h;
    logic signed [CW-1:0] d_h;
    logic signed [CW-1:0] y_s;

    assign u_h = u >> 1;
    assign v_h = v >> 1;
    assign y_s = $signed({{G{1'b0}}, y});

    modinv_coef_half #(.W(W)) u_half_ab (
        .a_in  (a),
        .b_in  (b),
        .x     (x),
        .y     (y),
        .a_out (a_h),
        .b_out (b_h)
    );

    modinv_coef_half #(.W(W)) u_half_cd (
        .a_in  (c),
        .b_in  (d),
        .x     (x),
        .y     (y),
        .a_out (c_h),
        .b_out (d_h)
    );

    // Halving states are skipped whenever their operand is already odd, so no
    // cycle is spent on a no-op visit; this keeps completion within 4W+8.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x       <= ine;
            y       <= inm;
            u       <= '0;
            v       <= '0;
            a       <= '0;
            b       <= '0;
            c       <= '0;
            d       <= '0;
            result  <= '0;
            err     <= 1'b0;
            ready_n <= 1'b1;
            state   <= S_CHK;
        end else begin
            unique case (state)
                S_CHK: begin
                    if (x == '0 || y == '0 || (!x[0] && !y[0])) begin
                        result  <= '0;
                        err     <= 1'b1;
                        ready_n <= 1'b0;
                        state   <= S_ERR;
                    end else if (y == W'(1)) begin
                        result  <= '0;
                        ready_n <= 1'b0;
                        state   <= S_DONE;
                    end else begin
                        u     <= x;
                        v     <= y;
                        a     <= CW'(1);
                        b     <= '0;
                        c     <= '0;
                        d     <= CW'(1);
                        state <= x[0] ? (y[0] ? S_SUB : S_V) : S_U;
                    end
                end
                S_U: begin
                    if (u[0]) begin
                        state <= v[0] ? S_SUB : S_V;
                    end else begin
                        u <= u_h;
                        a <= a_h;
                        b <= b_h;
                        if (u_h[0]) state <= v[0] ? S_SUB : S_V;
                    end
                end
                S_V: begin
                    if (v[0]) begin
                        state <= S_SUB;
                    end else begin
                        v <= v_h;
                        c <= c_h;
                        d <= d_h;
                        if (v_h[0]) state <= S_SUB;
                    end
                end
                S_SUB: begin
                    if (u >= v) begin
                        u     <= u - v;
                        a     <= a - c;
                        b     <= b - d;
                        state <= (u == v) ? S_GCD : S_U;
                    end else begin
                        v     <= v - u;
                        c     <= c - a;
                        d     <= d - b;
                        state <= S_V;
                    end
                end
                S_GCD: begin
                    if (v != W'(1)) begin
                        result  <= '0;
                        err     <= 1'b1;
                        ready_n <= 1'b0;
                        state   <= S_ERR;
                    end else begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (c < 0) begin
                        c <= c + y_s;
                    end else if (c >= y_s) begin
                        c <= c - y_s;
                    end else begin
                        result  <= c[W-1:0];
                        ready_n <= 1'b0;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    ready_n <= 1'b0;
                    err     <= 1'b0;
                end
                S_ERR: begin
                    ready_n <= 1'b0;
                    err     <= 1'b1;
                    result  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modinv_64.sv
// Directed checks of modinv_64 against hand-computed inverses and error cases.
module tb_modinv_64;
    import modinv_64_pkg::*;

    localparam int unsigned W     = RSA_W;
    localparam int          LIMIT = 264;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] ine = '0;
    logic [W-1:0] inm = '0;
    logic [W-1:0] result;
    logic         err;
    logic         ready_n;

    int checks = 0;
    int errors = 0;
    int cyc;

    logic [2*W-1:0] prod;
    logic [2*W-1:0] rem;
    logic [W-1:0]   big_m;

    always #5 clk = ~clk;

    modinv_64 #(.W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ine     (ine),
        .inm     (inm),
        .result  (result),
        .err     (err),
        .ready_n (ready_n)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [W-1:0] e, input logic [W-1:0] m);
        @(negedge clk);
        rst_n = 1'b0;
        ine   = e;
        inm   = m;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (ready_n !== 1'b0 && n < LIMIT + 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready_n", W'(ready_n), W'(1));
        check("rst_err", W'(err), W'(0));
        check("rst_result", result, W'(0));

        // 17^-1 mod 780 = 413, then hold
        start(W'(17), W'(780));
        wait_done(cyc);
        check("e17_in_time", W'(cyc <= LIMIT), W'(1));
        check("e17_result", result, W'(413));
        check("e17_err", W'(err), W'(0));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("e17_hold_result", result, W'(413));
            check("e17_hold_ready_n", W'(ready_n), W'(0));
        end

        // e > m, and the equivalent reduced exponent
        start(W'(43), W'(40));
        wait_done(cyc);
        check("e43_result", result, W'(27));
        check("e43_err", W'(err), W'(0));
        start(W'(3), W'(40));
        wait_done(cyc);
        check("e3_result", result, W'(27));
        check("e3_err", W'(err), W'(0));

        // Non-coprime operands
        start(W'(6), W'(9));
        wait_done(cyc);
        check("e6m9_err", W'(err), W'(1));
        check("e6m9_result", result, W'(0));
        check("e6m9_ready_n", W'(ready_n), W'(0));
        start(W'(4), W'(8));
        wait_done(cyc);
        check("e4m8_fast", W'(cyc <= 2), W'(1));
        check("e4m8_err", W'(err), W'(1));

        // Zero operands and trivial modulus
        start(W'(0), W'(780));
        wait_done(cyc);
        check("e0_err", W'(err), W'(1));
        start(W'(5), W'(0));
        wait_done(cyc);
        check("m0_err", W'(err), W'(1));
        start(W'(5), W'(1));
        wait_done(cyc);
        check("m1_err", W'(err), W'(0));
        check("m1_result", result, W'(0));
        check("m1_ready_n", W'(ready_n), W'(0));

        // Full-width modulus, verified by multiplication in the bench
        big_m = 64'hFFFF_FFFF_FFFF_FFFE;
        start(W'(65537), big_m);
        wait_done(cyc);
        check("big_in_time", W'(cyc <= LIMIT), W'(1));
        check("big_err", W'(err), W'(0));
        check("big_lt_m", W'(result < big_m), W'(1));
        prod = {{W{1'b0}}, result} * (2*W)'(65537);
        rem  = prod % {{W{1'b0}}, big_m};
        check("big_inverse", rem[W-1:0], W'(1));

        // Abort mid-run with new operands
        start(W'(17), W'(780));
        repeat (12) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        ine   = W'(7);
        inm   = W'(40);
        @(posedge clk);
        #1;
        check("abort_ready_n", W'(ready_n), W'(1));
        check("abort_result", result, W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        wait_done(cyc);
        check("abort_in_time", W'(cyc <= LIMIT), W'(1));
        check("abort_result_e7", result, W'(23));
        check("abort_err", W'(err), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
